regfile_sb: RTL and testbench
=============================

Name: regfile_sb

Overview:
- Parametrised general-purpose register file with multi-port read, dual-port write and a per-register busy scoreboard.
- Generalises the fixed 8x16 two-read/one-write file: width, depth and read-port count are parametrised; write-first bypass and a zero register are selectable.
- The decode stage reads operands and marks load destinations busy at issue.
- The ALU writeback uses port 0; the load/memory writeback uses port 1 and clears busy.

Parameters:
XLEN, 16, data width in bits
NREGS, 8, number of architectural registers (power of 2, >=2)
NRPORTS, 2, number of read ports (1..4)
ZERO_REG, 1, 1: register 0 reads as 0, ignores writes and busy-set
BYPASS, 1, 1: same-cycle write data forwarded to read ports

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
raddr  in  NRPORTS x AW  read addresses, AW=$clog2(NREGS)
rdata  out  NRPORTS x XLEN  read data, combinational
rready  out  NRPORTS  operand valid (not pending)
wen0  in  1  ALU write enable
waddr0  in  AW  ALU write address
wdata0  in  XLEN  ALU write data
wen1  in  1  load write enable; also clears busy
waddr1  in  AW  load write address
wdata1  in  XLEN  load write data
set_busy  in  1  mark set_addr pending (issue of load)
set_addr  in  AW  register to mark
busy_vec  out  NREGS  registered scoreboard
any_busy  out  1  OR of busy_vec
proto_err  out  1  registered one-cycle pulse on protocol violation

Behaviour:
- Reset (rst high at posedge): all registers 0, busy_vec 0, proto_err 0. Reset wins over all same-cycle writes and sets; pending loads are discarded.
- Writes take effect at posedge.
- wen0 and wen1 to the same address in the same cycle: port 0 data is stored. This is the younger instruction. Busy is still cleared by port 1.
- ZERO_REG=1: writes and set_busy to address 0 are ignored. rdata for address 0 is 0 and rready is 1.
- Read path, BYPASS=0: rdata = stored value, zero latency (combinational).
- Read path, BYPASS=1: if wen0 && waddr0==raddr, rdata=wdata0; else if wen1 && waddr1==raddr, rdata=wdata1; else stored value. Port 0 has priority, matching the write rule. The address-0 rule overrides bypass.
- Scoreboard next state, per register r:
  - busy[r] <= (set_busy && set_addr==r) ? 1 : (wen1 && waddr1==r) ? 0 : busy[r]
  - Simultaneous set and clear on the same r: set wins, so the register stays busy.
- rready[p]:
  - 1 if busy[raddr[p]]==0.
  - If BYPASS=1, also 1 when busy but wen1 && waddr1==raddr[p] in the same cycle.
  - Same-cycle set_busy does not affect rready; it is visible from the next cycle.
- proto_err is asserted the cycle after any of:
  - (a) set_busy to an address already busy and not cleared in the same cycle;
  - (b) wen1 to an address not busy;
  - (c) wen0 to an address busy and not cleared in the same cycle (WAW hazard).
- The violating operation still executes per the rules above.
- any_busy = |busy_vec, registered-derived; no combinational path from inputs.

Decomposition:
- Package regfile_pkg:
  - XLEN_DEF, NREGS_DEF
  - function-based AW derivation
  - typedef reg_addr_t (logic [AW-1:0] at defaults)
  - typedef xword_t (logic [XLEN-1:0])
- One sub-module, regfile_scoreboard: owns busy_vec, set/clear priority, proto_err generation and the rready logic.
- Storage and bypass muxing stay in regfile_sb, as a generate loop over NRPORTS.

Test Plan:
1. Reset, then wen0=1 waddr0=3 wdata0=16'hBEEF; next cycle raddr[0]=3 -> rdata[0]=BEEF, rready[0]=1. raddr[1]=0 -> 0.
2. Bypass: wen0=1 waddr0=5 wdata0=16'h1234 with raddr[1]=5 in the same cycle -> rdata[1]=1234. With BYPASS=0 -> old value 0.
3. Dual write conflict: wen0 waddr0=2 data 16'hAAAA and wen1 waddr1=2 data 16'h5555, with busy[2] set beforehand -> reg2=AAAA, busy[2]=0, proto_err=0.
4. Scoreboard:
   - set_busy addr 4 -> busy_vec=8'h10 next cycle, rready=0 for raddr 4.
   - wen1 waddr1=4 data 16'h0F0F -> same-cycle rready=1 and rdata=0F0F (BYPASS=1); next cycle busy_vec=0.
5. Set and clear on the same register in the same cycle (busy[6]=1, set_busy 6, wen1 6) -> busy[6] stays 1, proto_err=0. Then set_busy 6 again alone -> proto_err pulses 1 cycle.
6. Reset mid-operation with busy_vec=8'h82 and reg7=16'hFFFF -> next cycle busy_vec=0, reg7=0, any_busy=0. Write/set_busy to address 0 -> ignored, rdata=0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared sizing defaults, address-width helper and word/address types
// for the register file slice.
package regfile_pkg;

    localparam int XLEN_DEF  = 16;
    localparam int NREGS_DEF = 8;

    // Address width for a register count; never narrower than one bit.
    function automatic int addr_width(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

    localparam int AW_DEF = addr_width(NREGS_DEF);

    typedef logic [AW_DEF-1:0]   reg_addr_t;
    typedef logic [XLEN_DEF-1:0] xword_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending-load scoreboard: busy set/clear, operand-ready
// flags per read port and registered protocol-violation pulse.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREGS    = NREGS_DEF,
    parameter int NRPORTS  = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    parameter int AW       = addr_width(NREGS)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NRPORTS-1:0][AW-1:0]  raddr,
    input  logic                        wen0,
    input  logic [AW-1:0]               waddr0,
    input  logic                        wen1,
    input  logic [AW-1:0]               waddr1,
    input  logic                        set_busy,
    input  logic [AW-1:0]               set_addr,
    output logic [NRPORTS-1:0]          rready,
    output logic [NREGS-1:0]            busy_vec,
    output logic                        any_busy,
    output logic                        proto_err
);

    logic [NREGS-1:0] busy_reg;
    logic [NREGS-1:0] busy_next;
    logic             proto_err_reg;
    logic             proto_err_next;
    logic             set_eff;
    logic             clr_eff;
    logic             wr0_eff;

    // With a hard-wired zero register, operations on r0 are no-ops and are
    // also exempt from protocol checking.
    assign set_eff = set_busy && !((ZERO_REG != 0) && (set_addr == '0));
    assign clr_eff = wen1     && !((ZERO_REG != 0) && (waddr1   == '0));
    assign wr0_eff = wen0     && !((ZERO_REG != 0) && (waddr0   == '0));

    always_comb begin
        busy_next = busy_reg;
        for (int r = 0; r < NREGS; r++) begin
            if (set_eff && (set_addr == AW'(r))) begin
                busy_next[r] = 1'b1;
            end else if (clr_eff && (waddr1 == AW'(r))) begin
                busy_next[r] = 1'b0;
            end
        end
    end

    always_comb begin
        proto_err_next = 1'b0;
        if (set_eff && busy_reg[set_addr] && !(clr_eff && (waddr1 == set_addr))) begin
            proto_err_next = 1'b1;
        end
        if (clr_eff && !busy_reg[waddr1]) begin
            proto_err_next = 1'b1;
        end
        if (wr0_eff && busy_reg[waddr0] && !(clr_eff && (waddr1 == waddr0))) begin
            proto_err_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_reg      <= '0;
            proto_err_reg <= 1'b0;
        end else begin
            busy_reg      <= busy_next;
            proto_err_reg <= proto_err_next;
        end
    end

    generate
        for (genvar gi = 0; gi < NRPORTS; gi++) begin : g_ready
            logic fwd_hit;
            assign fwd_hit    = (BYPASS != 0) && clr_eff && (waddr1 == raddr[gi]);
            assign rready[gi] = !busy_reg[raddr[gi]] || fwd_hit;
        end
    endgenerate

    assign busy_vec  = busy_reg;
    assign any_busy  = |busy_reg;
    assign proto_err = proto_err_reg;

endmodule

// File: rtl/regfile_sb.sv
// Parametrised register file: NRPORTS combinational read ports with
// optional write-first forwarding, ALU and load write ports, scoreboard.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int NREGS    = NREGS_DEF,
    parameter int NRPORTS  = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    localparam int AW      = addr_width(NREGS)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NRPORTS-1:0][AW-1:0]   raddr,
    output logic [NRPORTS-1:0][XLEN-1:0] rdata,
    output logic [NRPORTS-1:0]           rready,
    input  logic                         wen0,
    input  logic [AW-1:0]                waddr0,
    input  logic [XLEN-1:0]              wdata0,
    input  logic                         wen1,
    input  logic [AW-1:0]                waddr1,
    input  logic [XLEN-1:0]              wdata1,
    input  logic                         set_busy,
    input  logic [AW-1:0]                set_addr,
    output logic [NREGS-1:0]             busy_vec,
    output logic                         any_busy,
    output logic                         proto_err
);

    logic [XLEN-1:0] regs_reg [NREGS];

    // Port 0 is the younger instruction, so its write lands last.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_reg[i] <= '0;
            end
        end else begin
            if (wen1 && !((ZERO_REG != 0) && (waddr1 == '0))) begin
                regs_reg[waddr1] <= wdata1;
            end
            if (wen0 && !((ZERO_REG != 0) && (waddr0 == '0))) begin
                regs_reg[waddr0] <= wdata0;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NRPORTS; gi++) begin : g_rd
            always_comb begin
                rdata[gi] = regs_reg[raddr[gi]];
                if (BYPASS != 0) begin
                    if (wen0 && (waddr0 == raddr[gi])) begin
                        rdata[gi] = wdata0;
                    end else if (wen1 && (waddr1 == raddr[gi])) begin
                        rdata[gi] = wdata1;
                    end
                end
                if ((ZERO_REG != 0) && (raddr[gi] == '0)) begin
                    rdata[gi] = '0;
                end
            end
        end
    endgenerate

    regfile_scoreboard #(
        .NREGS    (NREGS),
        .NRPORTS  (NRPORTS),
        .ZERO_REG (ZERO_REG),
        .BYPASS   (BYPASS),
        .AW       (AW)
    ) u_sb (
        .clk       (clk),
        .rst       (rst),
        .raddr     (raddr),
        .wen0      (wen0),
        .waddr0    (waddr0),
        .wen1      (wen1),
        .waddr1    (waddr1),
        .set_busy  (set_busy),
        .set_addr  (set_addr),
        .rready    (rready),
        .busy_vec  (busy_vec),
        .any_busy  (any_busy),
        .proto_err (proto_err)
    );

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: a forwarding instance and a non-forwarding
// instance share stimulus; every check is an immediate assertion.
module tb_regfile_sb;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0][2:0]  raddr;
    logic [1:0][15:0] rdata, nb_rdata;
    logic [1:0]       rready, nb_rready;
    logic             wen0, wen1, set_busy;
    logic [2:0]       waddr0, waddr1, set_addr;
    logic [15:0]      wdata0, wdata1;
    logic [7:0]       busy_vec, nb_busy_vec;
    logic             any_busy, nb_any_busy;
    logic             proto_err, nb_proto_err;

    int vectors = 0;
    int errs    = 0;

    always #5 clk = ~clk;

    regfile_sb #(.XLEN(16), .NREGS(8), .NRPORTS(2), .ZERO_REG(1), .BYPASS(1)) dut (
        .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdata), .rready(rready),
        .wen0(wen0), .waddr0(waddr0), .wdata0(wdata0),
        .wen1(wen1), .waddr1(waddr1), .wdata1(wdata1),
        .set_busy(set_busy), .set_addr(set_addr),
        .busy_vec(busy_vec), .any_busy(any_busy), .proto_err(proto_err)
    );

    regfile_sb #(.XLEN(16), .NREGS(8), .NRPORTS(2), .ZERO_REG(1), .BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst), .raddr(raddr), .rdata(nb_rdata), .rready(nb_rready),
        .wen0(wen0), .waddr0(waddr0), .wdata0(wdata0),
        .wen1(wen1), .waddr1(waddr1), .wdata1(wdata1),
        .set_busy(set_busy), .set_addr(set_addr),
        .busy_vec(nb_busy_vec), .any_busy(nb_any_busy), .proto_err(nb_proto_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance past a rising edge; inputs change and outputs are sampled 1ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wen0 = 1'b0; wen1 = 1'b0; set_busy = 1'b0;
    endtask

    initial begin
        rst = 1'b1; raddr = '0; idle();
        waddr0 = '0; waddr1 = '0; set_addr = '0; wdata0 = '0; wdata1 = '0;
        tick(); tick();
        rst = 1'b0; raddr[0] = 3'd3; raddr[1] = 3'd0;
        #1;
        chk("reset_busy_vec", busy_vec, 8'h00);
        chk("reset_any_busy", any_busy, 1'b0);
        chk("reset_proto_err", proto_err, 1'b0);
        chk("reset_reg3", rdata[0], 16'h0000);

        // Plain write then read back
        wen0 = 1'b1; waddr0 = 3'd3; wdata0 = 16'hBEEF;
        tick(); idle();
        #1;
        chk("wr_rd_reg3", rdata[0], 16'hBEEF);
        chk("wr_rd_ready", rready[0], 1'b1);
        chk("rd_zero_reg", rdata[1], 16'h0000);
        chk("rd_zero_ready", rready[1], 1'b1);

        // Same-cycle forwarding vs. no forwarding
        wen0 = 1'b1; waddr0 = 3'd5; wdata0 = 16'h1234; raddr[1] = 3'd5;
        #1;
        chk("bypass_port0", rdata[1], 16'h1234);
        chk("nobypass_old", nb_rdata[1], 16'h0000);
        tick(); idle();
        #1;
        chk("nobypass_stored", nb_rdata[1], 16'h1234);

        // Dual write to same address with pending load on it
        set_busy = 1'b1; set_addr = 3'd2;
        tick(); idle();
        #1;
        chk("busy2_set", busy_vec, 8'h04);
        chk("busy2_noerr", proto_err, 1'b0);
        wen0 = 1'b1; waddr0 = 3'd2; wdata0 = 16'hAAAA;
        wen1 = 1'b1; waddr1 = 3'd2; wdata1 = 16'h5555; raddr[0] = 3'd2;
        #1;
        chk("dual_bypass_prio", rdata[0], 16'hAAAA);
        tick(); idle();
        #1;
        chk("dual_stored", rdata[0], 16'hAAAA);
        chk("dual_busy_clr", busy_vec, 8'h00);
        chk("dual_noerr", proto_err, 1'b0);

        // Scoreboard set, forwarded clear
        set_busy = 1'b1; set_addr = 3'd4; raddr[0] = 3'd4;
        #1;
        chk("set_same_cycle_ready", rready[0], 1'b1);
        tick(); idle();
        #1;
        chk("busy4_vec", busy_vec, 8'h10);
        chk("busy4_ready", rready[0], 1'b0);
        chk("busy4_any", any_busy, 1'b1);
        wen1 = 1'b1; waddr1 = 3'd4; wdata1 = 16'h0F0F;
        #1;
        chk("load_fwd_ready", rready[0], 1'b1);
        chk("load_fwd_data", rdata[0], 16'h0F0F);
        chk("load_nb_ready", nb_rready[0], 1'b0);
        chk("load_nb_data", nb_rdata[0], 16'h0000);
        tick(); idle();
        #1;
        chk("load_busy_clr", busy_vec, 8'h00);
        chk("load_noerr", proto_err, 1'b0);
        chk("load_stored", rdata[0], 16'h0F0F);

        // Set and clear same register same cycle: set wins
        set_busy = 1'b1; set_addr = 3'd6;
        tick();
        wen1 = 1'b1; waddr1 = 3'd6; wdata1 = 16'h6666;
        tick(); idle();
        #1;
        chk("setclr_busy", busy_vec, 8'h40);
        chk("setclr_noerr", proto_err, 1'b0);
        set_busy = 1'b1; set_addr = 3'd6;
        tick(); idle();
        #1;
        chk("dbl_set_err", proto_err, 1'b1);
        chk("dbl_set_busy", busy_vec, 8'h40);
        tick();
        chk("err_pulse_end", proto_err, 1'b0);

        // Load to a register that is not busy
        wen1 = 1'b1; waddr1 = 3'd3; wdata1 = 16'h3333;
        tick(); idle();
        #1;
        chk("load_notbusy_err", proto_err, 1'b1);
        // WAW: ALU write to pending register 6
        wen0 = 1'b1; waddr0 = 3'd6; wdata0 = 16'h7777;
        tick(); idle();
        #1;
        chk("waw_err", proto_err, 1'b1);
        wen1 = 1'b1; waddr1 = 3'd6; wdata1 = 16'h6060;
        tick(); idle();
        #1;
        chk("waw_clr_noerr", proto_err, 1'b0);
        chk("waw_clr_busy", busy_vec, 8'h00);

        // Reset mid-operation, overriding same-cycle write and set
        wen0 = 1'b1; waddr0 = 3'd7; wdata0 = 16'hFFFF;
        tick(); idle();
        set_busy = 1'b1; set_addr = 3'd7;
        tick();
        set_addr = 3'd1;
        tick(); idle();
        #1;
        chk("pre_rst_busy", busy_vec, 8'h82);
        raddr[0] = 3'd7;
        #1;
        chk("pre_rst_reg7", rdata[0], 16'hFFFF);
        rst = 1'b1; wen0 = 1'b1; waddr0 = 3'd5; wdata0 = 16'h1111;
        set_busy = 1'b1; set_addr = 3'd3;
        tick();
        rst = 1'b0; idle();
        #1;
        chk("rst_busy_vec", busy_vec, 8'h00);
        chk("rst_any_busy", any_busy, 1'b0);
        chk("rst_reg7", rdata[0], 16'h0000);
        raddr[0] = 3'd5;
        #1;
        chk("rst_beats_write", rdata[0], 16'h0000);

        // Address 0 ignores writes, busy-set and forwarding
        wen0 = 1'b1; waddr0 = 3'd0; wdata0 = 16'h9999;
        set_busy = 1'b1; set_addr = 3'd0; raddr[0] = 3'd0;
        #1;
        chk("zero_no_bypass", rdata[0], 16'h0000);
        tick(); idle();
        #1;
        chk("zero_stored", rdata[0], 16'h0000);
        chk("zero_ready", rready[0], 1'b1);
        chk("zero_busy", busy_vec, 8'h00);
        chk("zero_noerr", proto_err, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
